// File: rtl/inta_sequencer.sv
// Sequences the two-pulse 8259 INTA cycle: synchronizes inta_n, strobes the
// phases for the resolver, and drives the vector, cascade and AEOI controls.
module inta_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int GAP_TIMEOUT = 255,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inta_n,
  input  logic       init_done,
  input  logic       sngl,
  input  logic       sp_en,
  input  logic [7:0] icw3,
  input  logic       aeoi,
  input  logic [2:0] cas_in,
  input  logic       int_pending,
  input  logic [2:0] grant_idx,
  input  logic [4:0] vector_base,
  output logic       ack1_start,
  output logic       ack1_end,
  output logic       ack2_start,
  output logic       ack2_end,
  output logic       aeoi_clr,
  output logic [2:0] idx_q,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic       spurious,
  output logic       abort,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACK1 = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] ACK2 = 2'd3;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic [TW-1:0]          gap_cnt;
  logic                   slave_match_q;

  logic inta_s, fall, rise;
  logic cas_match, master_casc, vec_sel, resp_ack2, resp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      edge_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    inta_s      = sync_q[SYNC_STAGES-1];
    fall        = edge_q & ~inta_s;
    rise        = ~edge_q & inta_s;
    cas_match   = (cas_in == icw3[2:0]);
    master_casc = ~sngl & sp_en & icw3[idx_q];
    // Master supplies the vector only when the serviced IR has no slave behind it
    vec_sel     = sngl | ~sp_en | ~icw3[idx_q];
    resp_ack2   = sngl | sp_en | cas_match;
    resp_q      = sngl | sp_en | slave_match_q;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ack1_start    <= 1'b0;
      ack1_end      <= 1'b0;
      ack2_start    <= 1'b0;
      ack2_end      <= 1'b0;
      aeoi_clr      <= 1'b0;
      abort         <= 1'b0;
      idx_q         <= '0;
      data_out      <= '0;
      data_oe       <= 1'b0;
      cas_out       <= '0;
      cas_oe        <= 1'b0;
      spurious      <= 1'b0;
      gap_cnt       <= '0;
      slave_match_q <= 1'b0;
    end else begin
      ack1_start <= 1'b0;
      ack1_end   <= 1'b0;
      ack2_start <= 1'b0;
      ack2_end   <= 1'b0;
      aeoi_clr   <= 1'b0;
      abort      <= 1'b0;
      data_out   <= {vector_base, idx_q};
      if (!init_done) begin
        state   <= IDLE;
        data_oe <= 1'b0;
        cas_oe  <= 1'b0;
        cas_out <= '0;
      end else begin
        case (state)
          IDLE: begin
            data_oe <= 1'b0;
            cas_oe  <= 1'b0;
            cas_out <= '0;
            if (fall) begin
              state      <= ACK1;
              ack1_start <= 1'b1;
              spurious   <= 1'b0;
            end
          end
          ACK1: begin
            if (rise) begin
              ack1_end <= 1'b1;
              gap_cnt  <= '0;
              state    <= GAP;
              if (int_pending) begin
                idx_q <= grant_idx;
              end else begin
                idx_q    <= 3'd7;
                spurious <= 1'b1;
              end
            end
          end
          GAP: begin
            cas_oe  <= master_casc;
            cas_out <= master_casc ? idx_q : 3'd0;
            if (fall) begin
              state         <= ACK2;
              ack2_start    <= 1'b1;
              slave_match_q <= cas_match;
              data_oe       <= resp_ack2 & vec_sel;
            end else if (gap_cnt == TW'(GAP_TIMEOUT)) begin
              abort   <= 1'b1;
              state   <= IDLE;
              cas_oe  <= 1'b0;
              cas_out <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          ACK2: begin
            // cas_oe is left up so it covers the ack2_end cycle; IDLE drops it
            if (rise) begin
              ack2_end <= 1'b1;
              aeoi_clr <= aeoi & resp_q & ~spurious;
              data_oe  <= 1'b0;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Scoreboard bench for inta_sequencer: stimulus queues expected strobe events,
// a negedge monitor pops and compares whenever any strobe is observed.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inta_n;
  logic       init_done;
  logic       sngl;
  logic       sp_en;
  logic [7:0] icw3;
  logic       aeoi;
  logic [2:0] cas_in;
  logic       int_pending;
  logic [2:0] grant_idx;
  logic [4:0] vector_base;
  logic       ack1_start, ack1_end, ack2_start, ack2_end, aeoi_clr;
  logic [2:0] idx_q;
  logic [7:0] data_out;
  logic       data_oe;
  logic [2:0] cas_out;
  logic       cas_oe;
  logic       spurious, abort, busy;

  always #5 clk = ~clk;

  inta_sequencer #(.SYNC_STAGES(2), .GAP_TIMEOUT(255), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n), .inta_n(inta_n), .init_done(init_done),
    .sngl(sngl), .sp_en(sp_en), .icw3(icw3), .aeoi(aeoi), .cas_in(cas_in),
    .int_pending(int_pending), .grant_idx(grant_idx), .vector_base(vector_base),
    .ack1_start(ack1_start), .ack1_end(ack1_end), .ack2_start(ack2_start),
    .ack2_end(ack2_end), .aeoi_clr(aeoi_clr), .idx_q(idx_q), .data_out(data_out),
    .data_oe(data_oe), .cas_out(cas_out), .cas_oe(cas_oe), .spurious(spurious),
    .abort(abort), .busy(busy)
  );

  // strb = {ack1_start, ack1_end, ack2_start, ack2_end, aeoi_clr, abort}
  typedef struct {
    logic [5:0] strb;
    logic       busy;
    logic       sp;
    logic       chk_idx;
    logic [2:0] idx;
    logic       chk_data;
    logic [7:0] dout;
    logic       oe;
    logic       cas_oe;
    logic [2:0] cas_out;
  } ev_t;

  ev_t exq[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [5:0] s, input logic b, input logic sp,
                      input logic ci, input logic [2:0] idx, input logic cd,
                      input logic oe, input logic co);
    ev_t e;
    e.strb = s; e.busy = b; e.sp = sp; e.chk_idx = ci; e.idx = idx;
    e.chk_data = cd; e.dout = {vector_base, idx}; e.oe = oe;
    e.cas_oe = co; e.cas_out = idx;
    exq.push_back(e);
  endtask

  task automatic full_cycle(input logic [2:0] idx, input logic sp, input logic oe,
                            input logic co, input logic clr);
    push(6'b100000, 1'b1, 1'b0, 1'b0, idx, 1'b0, 1'b0, 1'b0);
    push(6'b010000, 1'b1, sp,   1'b1, idx, 1'b0, 1'b0, 1'b0);
    push(6'b001000, 1'b1, sp,   1'b1, idx, 1'b1, oe,   co);
    push({4'b0001, clr, 1'b0}, 1'b0, sp, 1'b1, idx, 1'b1, 1'b0, co);
    inta_n = 1'b0; step(4);
    inta_n = 1'b1; step(6);
    inta_n = 1'b0; step(4);
    inta_n = 1'b1; step(8);
  endtask

  initial begin : monitor
    logic [5:0] s;
    ev_t        e;
    forever begin
      @(negedge clk);
      s = {ack1_start, ack1_end, ack2_start, ack2_end, aeoi_clr, abort};
      if (rst_n && s != 6'b0) begin
        if (exq.size() == 0) begin
          chk("unexpected_strobe", {26'b0, s}, 32'h0);
        end else begin
          e = exq.pop_front();
          chk("strobes", {26'b0, s}, {26'b0, e.strb});
          chk("busy", {31'b0, busy}, {31'b0, e.busy});
          chk("spurious", {31'b0, spurious}, {31'b0, e.sp});
          chk("data_oe", {31'b0, data_oe}, {31'b0, e.oe});
          chk("cas_oe", {31'b0, cas_oe}, {31'b0, e.cas_oe});
          if (e.chk_idx)  chk("idx_q", {29'b0, idx_q}, {29'b0, e.idx});
          if (e.chk_data) chk("data_out", {24'b0, data_out}, {24'b0, e.dout});
          if (e.cas_oe)   chk("cas_out", {29'b0, cas_out}, {29'b0, e.cas_out});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; inta_n = 1'b1; init_done = 1'b1; sngl = 1'b1; sp_en = 1'b1;
    icw3 = 8'h00; aeoi = 1'b0; cas_in = 3'b000; int_pending = 1'b1;
    grant_idx = 3'd3; vector_base = 5'b01000;
    #1;
    chk("rst_strobes", {26'b0, ack1_start, ack1_end, ack2_start, ack2_end, aeoi_clr, abort}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_data_oe", {31'b0, data_oe}, 32'h0);
    chk("rst_cas_oe", {31'b0, cas_oe}, 32'h0);
    chk("rst_idx_q", {29'b0, idx_q}, 32'h0);
    chk("rst_data_out", {24'b0, data_out}, 32'h0);
    chk("rst_spurious", {31'b0, spurious}, 32'h0);
    step(3); rst_n = 1'b1; step(3);

    // single mode, no AEOI, then with AEOI: vector 8'h43
    full_cycle(3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    aeoi = 1'b1;
    full_cycle(3'd3, 1'b0, 1'b1, 1'b0, 1'b1);

    // master with slave on IR2
    sngl = 1'b0; sp_en = 1'b1; icw3 = 8'h04; aeoi = 1'b0; grant_idx = 3'd2;
    full_cycle(3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    grant_idx = 3'd5;
    full_cycle(3'd5, 1'b0, 1'b1, 1'b0, 1'b0);

    // slave with ID 2
    sp_en = 1'b0; icw3 = 8'h02; aeoi = 1'b1; grant_idx = 3'd6; cas_in = 3'b010;
    full_cycle(3'd6, 1'b0, 1'b1, 1'b0, 1'b1);
    cas_in = 3'b011;
    full_cycle(3'd6, 1'b0, 1'b0, 1'b0, 1'b0);

    // spurious: no pending request, AEOI must not fire
    sngl = 1'b1; int_pending = 1'b0; aeoi = 1'b1; vector_base = 5'b10101;
    full_cycle(3'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    int_pending = 1'b1; aeoi = 1'b0;

    // second pulse withheld: abort once, then a fresh cycle
    grant_idx = 3'd4;
    push(6'b100000, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
    push(6'b010000, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    push(6'b000001, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    inta_n = 1'b0; step(4);
    inta_n = 1'b1; step(300);
    chk("busy_after_abort", {31'b0, busy}, 32'h0);
    grant_idx = 3'd1;
    full_cycle(3'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    // edges ignored before initialization completes
    init_done = 1'b0;
    inta_n = 1'b0; step(4);
    chk("busy_uninit", {31'b0, busy}, 32'h0);
    inta_n = 1'b1; step(6);
    init_done = 1'b1; step(2);

    // asynchronous reset in the middle of ACK2
    grant_idx = 3'd3;
    push(6'b100000, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    push(6'b010000, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    push(6'b001000, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
    inta_n = 1'b0; step(4);
    inta_n = 1'b1; step(6);
    inta_n = 1'b0; step(6);
    chk("oe_in_ack2", {31'b0, data_oe}, 32'h1);
    rst_n = 1'b0; #1;
    chk("oe_after_rst", {31'b0, data_oe}, 32'h0);
    chk("busy_after_rst", {31'b0, busy}, 32'h0);
    chk("idx_after_rst", {29'b0, idx_q}, 32'h0);
    inta_n = 1'b1; step(3);
    rst_n = 1'b1; step(6);

    chk("queue_empty", exq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
